// File: rtl/decode_stage_pipe_if.sv
// Fetch-to-execute handshake bundle for the decode stage.
// The slave side is the decode stage; the master side is the surrounding fetch/execute logic.
interface decode_stage_pipe_if #(
    parameter int XLEN = 32,
    parameter int RIDW = 3
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_r1;
    logic [XLEN-1:0] out_r2;
    logic [XLEN-1:0] out_imm;
    logic [RIDW-1:0] out_rd;
    logic [3:0]      out_ex;
    logic [2:0]      out_mem;
    logic [1:0]      out_wb;

    modport master (
        output in_valid, inst, out_ready,
        input  in_ready, out_valid, out_r1, out_r2, out_imm, out_rd, out_ex, out_mem, out_wb
    );

    modport slave (
        input  in_valid, inst, out_ready,
        output in_ready, out_valid, out_r1, out_r2, out_imm, out_rd, out_ex, out_mem, out_wb
    );
endinterface

// File: rtl/decode_stage_pipe.sv
// Registered instruction-decode stage: register file with write-back bypass,
// opcode decode, immediate sign extension, load-use stall, flush and an ID/EX register.
module decode_stage_pipe #(
    parameter int XLEN      = 32,
    parameter int NREG      = 8,
    parameter int RIDW      = 3,
    parameter int RS1_LSB   = 16,
    parameter int RS2_LSB   = 13,
    parameter int RD_LSB    = 19,
    parameter int REG0_ZERO = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decode_stage_pipe_if.slave   bus,
    input  logic                 wb_en,
    input  logic [RIDW-1:0]      wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 hz_load,
    input  logic [RIDW-1:0]      hz_rd,
    input  logic                 flush
);

    // ctrl: [10] rs2 from rd field, [9] 22-bit immediate, [8:5] ex, [4:2] mem, [1:0] wb
    function automatic logic [10:0] alu_control(input logic [5:0] op);
        logic [10:0] c;
        case (op)
            6'h00:   c = {1'b0, 1'b0, 4'h0, 3'b000, 2'b10}; // reg-reg alu
            6'h01:   c = {1'b0, 1'b0, 4'h1, 3'b000, 2'b10}; // alu immediate
            6'h02:   c = {1'b0, 1'b0, 4'h2, 3'b010, 2'b11}; // load
            6'h03:   c = {1'b1, 1'b0, 4'h2, 3'b001, 2'b00}; // store
            6'h04:   c = {1'b0, 1'b1, 4'h4, 3'b000, 2'b10}; // long immediate
            6'h05:   c = {1'b1, 1'b1, 4'h5, 3'b100, 2'b00}; // branch
            default: c = '0;
        endcase
        return c;
    endfunction

    logic [XLEN-1:0] r_regs [NREG];
    logic            r_valid;
    logic [XLEN-1:0] r_r1;
    logic [XLEN-1:0] r_r2;
    logic [XLEN-1:0] r_imm;
    logic [RIDW-1:0] r_rd;
    logic [3:0]      r_ex;
    logic [2:0]      r_mem;
    logic [1:0]      r_wb;

    logic [10:0]     w_ctrl;
    logic [RIDW-1:0] w_rs1;
    logic [RIDW-1:0] w_rs2;
    logic [RIDW-1:0] w_rd;
    logic [XLEN-1:0] w_r1;
    logic [XLEN-1:0] w_r2;
    logic [XLEN-1:0] w_imm;
    logic            w_hz_match;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_wr_ok;
    logic            w_unused_bits;

    assign w_ctrl = alu_control(bus.inst[27:22]);
    assign w_rs1  = bus.inst[RS1_LSB +: RIDW];
    assign w_rd   = bus.inst[RD_LSB +: RIDW];
    assign w_rs2  = w_ctrl[10] ? w_rd : bus.inst[RS2_LSB +: RIDW];
    assign w_imm  = w_ctrl[9] ? XLEN'($signed(bus.inst[21:0])) : XLEN'($signed(bus.inst[15:0]));

    assign w_r1 = ((REG0_ZERO != 0) && (w_rs1 == '0)) ? '0 :
                  (wb_en && (wb_rd == w_rs1))          ? wb_data : r_regs[w_rs1];
    assign w_r2 = ((REG0_ZERO != 0) && (w_rs2 == '0)) ? '0 :
                  (wb_en && (wb_rd == w_rs2))          ? wb_data : r_regs[w_rs2];

    // in_valid is left out of the stall term so in_ready never depends on it;
    // when no instruction is offered the ready value has no effect.
    assign w_hz_match = hz_load && ((hz_rd == w_rs1) || (hz_rd == w_rs2));
    assign w_in_ready = flush || ((!r_valid || bus.out_ready) && !w_hz_match);
    assign w_accept   = bus.in_valid && w_in_ready && !flush;
    assign w_wr_ok    = wb_en && !((REG0_ZERO != 0) && (wb_rd == '0));

    assign w_unused_bits = ^bus.inst[31:28];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (w_wr_ok) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_r1    <= '0;
            r_r2    <= '0;
            r_imm   <= '0;
            r_rd    <= '0;
            r_ex    <= '0;
            r_mem   <= '0;
            r_wb    <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_r1    <= w_r1;
            r_r2    <= w_r2;
            r_imm   <= w_imm;
            r_rd    <= w_rd;
            r_ex    <= w_ctrl[8:5];
            r_mem   <= w_ctrl[4:2];
            r_wb    <= w_ctrl[1:0];
        end else if (bus.out_ready) begin
            // consumed downstream or bubble inserted behind a load-use stall
            r_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_valid;
    assign bus.out_r1    = r_r1;
    assign bus.out_r2    = r_r2;
    assign bus.out_imm   = r_imm;
    assign bus.out_rd    = r_rd;
    assign bus.out_ex    = r_ex;
    assign bus.out_mem   = r_mem;
    assign bus.out_wb    = r_wb;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe (REG0_ZERO=1) with hand-computed expectations.
module tb_decode_stage_pipe;
    localparam int XLEN = 32;
    localparam int RIDW = 3;

    logic            clk;
    logic            rst_n;
    logic            wb_en;
    logic [RIDW-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            hz_load;
    logic [RIDW-1:0] hz_rd;
    logic            flush;

    int n_checks = 0;
    int n_errors = 0;

    decode_stage_pipe_if #(.XLEN(XLEN), .RIDW(RIDW)) bif ();

    decode_stage_pipe #(.XLEN(XLEN), .NREG(8), .RIDW(RIDW), .REG0_ZERO(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bif.slave),
        .wb_en   (wb_en),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .hz_load (hz_load),
        .hz_rd   (hz_rd),
        .flush   (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inst layout: [27:22] opcode, [21:19] rd, [18:16] rs1, [15:0] imm16 (rs2 = imm16[15:13])
    function automatic logic [31:0] mk(input logic [5:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [15:0] imm16);
        return {4'h0, op, rd, rs1, imm16};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        wb_en         = 1'b0;
        wb_rd         = '0;
        wb_data       = '0;
        hz_load       = 1'b0;
        hz_rd         = '0;
        flush         = 1'b0;
        bif.in_valid  = 1'b0;
        bif.inst      = '0;
        bif.out_ready = 1'b1;
        #2;
        check("rst_valid", 32'(bif.out_valid), 32'd0);
        check("rst_r1",    bif.out_r1,         32'd0);
        check("rst_imm",   bif.out_imm,        32'd0);
        check("rst_wb",    32'(bif.out_wb),    32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // register write then decode reading it
        wb_en = 1'b1; wb_rd = 3'd5; wb_data = 32'h1234;
        tick();
        wb_en = 1'b0;
        bif.inst = mk(6'h01, 3'd1, 3'd5, 16'h0010);
        bif.in_valid = 1'b1;
        #1;
        check("t1_in_ready", 32'(bif.in_ready), 32'd1);
        tick();
        check("t1_valid", 32'(bif.out_valid), 32'd1);
        check("t1_r1",    bif.out_r1,         32'h1234);
        check("t1_r2",    bif.out_r2,         32'h0);
        check("t1_imm",   bif.out_imm,        32'h10);
        check("t1_rd",    32'(bif.out_rd),    32'd1);
        check("t1_ex",    32'(bif.out_ex),    32'h1);
        check("t1_wb",    32'(bif.out_wb),    32'h2);

        // same-cycle write-back bypass on rs1; rs2=5 from the register file
        wb_en = 1'b1; wb_rd = 3'd3; wb_data = 32'hAA;
        bif.inst = mk(6'h00, 3'd2, 3'd3, 16'hA000);
        tick();
        wb_en = 1'b0;
        check("t2_r1",  bif.out_r1,      32'hAA);
        check("t2_r2",  bif.out_r2,      32'h1234);
        check("t2_imm", bif.out_imm,     32'hFFFFA000);
        check("t2_rd",  32'(bif.out_rd), 32'd2);
        check("t2_mem", 32'(bif.out_mem),32'h0);

        // load-use stall on rs2 from the RS2 field
        hz_load = 1'b1; hz_rd = 3'd2;
        bif.inst = mk(6'h00, 3'd4, 3'd1, 16'h4000);
        #1;
        check("t3_stall_ready", 32'(bif.in_ready), 32'd0);
        tick();
        check("t3_bubble", 32'(bif.out_valid), 32'd0);
        hz_load = 1'b0;
        #1;
        check("t3_release_ready", 32'(bif.in_ready), 32'd1);
        tick();
        check("t3_valid", 32'(bif.out_valid), 32'd1);
        check("t3_rd",    32'(bif.out_rd),    32'd4);
        check("t3_imm",   bif.out_imm,        32'h4000);

        // load-use stall on rs2 taken from the rd field (store)
        hz_load = 1'b1; hz_rd = 3'd3;
        bif.inst = mk(6'h03, 3'd3, 3'd0, 16'h0000);
        #1;
        check("t3b_stall_ready", 32'(bif.in_ready), 32'd0);
        tick();
        check("t3b_bubble", 32'(bif.out_valid), 32'd0);
        hz_load = 1'b0;
        tick();
        check("t3b_valid", 32'(bif.out_valid), 32'd1);
        check("t3b_r2",    bif.out_r2,         32'hAA);
        check("t3b_ex",    32'(bif.out_ex),    32'h2);
        check("t3b_mem",   32'(bif.out_mem),   32'h1);
        check("t3b_wb",    32'(bif.out_wb),    32'h0);

        // downstream backpressure holds ID/EX for three cycles
        bif.out_ready = 1'b0;
        bif.inst = mk(6'h02, 3'd6, 3'd5, 16'h0004);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_hold_ready", 32'(bif.in_ready), 32'd0);
            tick();
            check("t4_hold_valid", 32'(bif.out_valid), 32'd1);
            check("t4_hold_rd",    32'(bif.out_rd),    32'd3);
            check("t4_hold_r2",    bif.out_r2,         32'hAA);
        end
        bif.out_ready = 1'b1;
        #1;
        check("t4_ready", 32'(bif.in_ready), 32'd1);
        tick();
        check("t4_rd",  32'(bif.out_rd),  32'd6);
        check("t4_r1",  bif.out_r1,       32'h1234);
        check("t4_imm", bif.out_imm,      32'h4);
        check("t4_mem", 32'(bif.out_mem), 32'h2);
        check("t4_wb",  32'(bif.out_wb),  32'h3);

        // drained with nothing new offered
        bif.in_valid = 1'b0;
        tick();
        check("drain_valid", 32'(bif.out_valid), 32'd0);

        // immediate sign extension, 16-bit and 22-bit forms
        bif.in_valid = 1'b1;
        bif.inst = mk(6'h00, 3'd0, 3'd0, 16'h8000);
        tick();
        check("t5_imm16", bif.out_imm, 32'hFFFF8000);
        bif.inst = mk(6'h04, 3'd4, 3'd0, 16'h0001);
        tick();
        check("t5_imm22_neg", bif.out_imm,      32'hFFE00001);
        check("t5_ex",        32'(bif.out_ex),  32'h4);
        bif.inst = mk(6'h04, 3'd3, 3'd0, 16'h0000);
        tick();
        check("t5_imm22_pos", bif.out_imm, 32'h00180000);

        // flush overrides backpressure and consumes the offered inst
        bif.out_ready = 1'b0;
        flush = 1'b1;
        bif.inst = mk(6'h01, 3'd1, 3'd5, 16'h0000);
        #1;
        check("t6_flush_ready", 32'(bif.in_ready), 32'd1);
        tick();
        check("t6_flush_valid", 32'(bif.out_valid), 32'd0);
        flush = 1'b0;
        bif.out_ready = 1'b1;

        // reg 0 ignores writes and is not bypassed
        wb_en = 1'b1; wb_rd = 3'd0; wb_data = 32'h7;
        bif.inst = mk(6'h01, 3'd1, 3'd0, 16'h0000);
        tick();
        wb_en = 1'b0;
        check("t6_r0_bypass", bif.out_r1, 32'h0);
        tick();
        check("t6_r0_read", bif.out_r1, 32'h0);
        check("t6_r0_valid", 32'(bif.out_valid), 32'd1);

        // asynchronous reset mid-operation
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(bif.out_valid), 32'd0);
        check("rst_mid_rd",    32'(bif.out_rd),    32'd0);
        tick();
        rst_n = 1'b1;
        bif.inst = mk(6'h01, 3'd1, 3'd5, 16'h0000);
        tick();
        check("rst_mid_regclr", bif.out_r1, 32'h0);
        check("rst_mid_accept", 32'(bif.out_valid), 32'd1);
        bif.in_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
